// File: rtl/vm_pkg.sv
// vm_pkg: coin codes, coin helpers and FSM state encoding shared by the vending machine.
package vm_pkg;
    localparam logic [1:0] COIN_1    = 2'b00;
    localparam logic [1:0] COIN_2    = 2'b01;
    localparam logic [1:0] COIN_5    = 2'b10;
    localparam logic [1:0] COIN_NONE = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        return code == COIN_1 ? 3'd1 : code == COIN_2 ? 3'd2 : code == COIN_5 ? 3'd5 : 3'd0;
    endfunction

    // Largest coin not exceeding bal; COIN_NONE once nothing is owed.
    function automatic logic [1:0] change_pick(input logic [31:0] bal);
        return bal >= 32'd5 ? COIN_5 : bal >= 32'd2 ? COIN_2 : bal >= 32'd1 ? COIN_1 : COIN_NONE;
    endfunction
endpackage

// File: rtl/vm_stock_bank.sv
// vm_stock_bank: per-item stock counters with vend decrement, saturating restock and low/sold-out flags.
module vm_stock_bank #(
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 5,
    parameter int LOW_THRESH = 1,
    localparam int IW = NUM_ITEMS > 1 ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_i,
    input  logic [IW-1:0]        dec_item_i,
    input  logic                 rs_i,
    input  logic [IW-1:0]        rs_item_i,
    input  logic [STOCK_W-1:0]   rs_qty_i,
    output logic [NUM_ITEMS-1:0] low_stock_o,
    output logic [NUM_ITEMS-1:0] sold_out_o
);
    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
        logic [STOCK_W:0] sum_d;
        // A vend only happens on a non-empty item, so the extra bit absorbs both the add and the subtract.
        always_comb begin
            sum_d = {1'b0, stock_q[i]}
                  + ((rs_i && rs_item_i == IW'(i)) ? {1'b0, rs_qty_i} : '0)
                  - ((dec_i && dec_item_i == IW'(i)) ? (STOCK_W+1)'(1) : '0);
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            else
                stock_q[i] <= sum_d[STOCK_W] ? '1 : sum_d[STOCK_W-1:0];
        end
        assign low_stock_o[i] = stock_q[i] <= STOCK_W'(LOW_THRESH);
        assign sold_out_o[i]  = stock_q[i] == '0;
    end
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item vending FSM with per-item stock, restock and coin-by-coin change.
module vending_machine_multi
    import vm_pkg::*;
#(
    parameter int NUM_ITEMS = 4,
    parameter int BAL_W = 7,
    parameter int MAX_BAL = 99,
    parameter logic [NUM_ITEMS*BAL_W-1:0] ITEM_PRICES = {7'd15, 7'd12, 7'd10, 7'd7},
    parameter int STOCK_W = 4,
    parameter int INIT_STOCK = 5,
    parameter int LOW_THRESH = 1,
    parameter bit AUTO_CHANGE = 1'b1,
    localparam int IW = NUM_ITEMS > 1 ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           coin_i,
    input  logic                 select_valid_i,
    input  logic [IW-1:0]        select_item_i,
    input  logic                 cancel_i,
    input  logic                 restock_i,
    input  logic [IW-1:0]        restock_item_i,
    input  logic [STOCK_W-1:0]   restock_qty_i,
    input  logic                 change_ready_i,
    output logic                 dispense_o,
    output logic [IW-1:0]        dispense_item_o,
    output logic                 deny_o,
    output logic                 coin_reject_o,
    output logic                 change_valid_o,
    output logic [1:0]           change_coin_o,
    output logic [BAL_W-1:0]     balance_o,
    output logic [NUM_ITEMS-1:0] low_stock_o,
    output logic [NUM_ITEMS-1:0] sold_out_o,
    output logic                 busy_o
);
    state_t               state_q;
    logic [BAL_W-1:0]     bal_q;
    logic [IW-1:0]        item_q;
    logic [1:0]           change_coin_q;
    logic                 dispense_q, deny_q, coin_reject_q, change_valid_q;
    logic [BAL_W-1:0]     price, change_left;
    logic [BAL_W:0]       coin_sum;
    logic                 idle, cancel_go, sel_go, coin_ok;
    logic [NUM_ITEMS-1:0] sold_out;

    always_comb begin
        idle        = state_q == S_IDLE;
        price       = ITEM_PRICES[select_item_i*BAL_W +: BAL_W];
        coin_sum    = {1'b0, bal_q} + (BAL_W+1)'(coin_value(coin_i));
        change_left = bal_q - BAL_W'(coin_value(change_coin_q));
        cancel_go   = idle && cancel_i && bal_q != '0;
        sel_go      = idle && !cancel_i && select_valid_i && bal_q >= price && !sold_out[select_item_i];
        // Any coin that is not credited here is pushed back out, including those racing a cancel or vend.
        coin_ok     = idle && !cancel_go && !sel_go && coin_i != COIN_NONE
                   && coin_sum <= (BAL_W+1)'(MAX_BAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            bal_q          <= '0;
            item_q         <= '0;
            dispense_q     <= 1'b0;
            deny_q         <= 1'b0;
            coin_reject_q  <= 1'b0;
            change_valid_q <= 1'b0;
            change_coin_q  <= COIN_NONE;
        end else begin
            dispense_q    <= 1'b0;
            deny_q        <= idle && !cancel_i && select_valid_i && !sel_go;
            coin_reject_q <= coin_i != COIN_NONE && !coin_ok;
            case (state_q)
                S_IDLE: begin
                    if (cancel_go) begin
                        state_q        <= S_CHANGE;
                        change_valid_q <= 1'b1;
                        change_coin_q  <= change_pick(32'(bal_q));
                    end else if (sel_go) begin
                        state_q    <= S_VEND;
                        bal_q      <= bal_q - price;
                        item_q     <= select_item_i;
                        dispense_q <= 1'b1;
                    end else if (coin_ok) begin
                        bal_q <= coin_sum[BAL_W-1:0];
                    end
                end
                S_VEND: begin
                    if (AUTO_CHANGE && bal_q != '0) begin
                        state_q        <= S_CHANGE;
                        change_valid_q <= 1'b1;
                        change_coin_q  <= change_pick(32'(bal_q));
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    if (change_ready_i) begin
                        bal_q         <= change_left;
                        change_coin_q <= change_pick(32'(change_left));
                        if (change_left == '0) begin
                            state_q        <= S_IDLE;
                            change_valid_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    vm_stock_bank #(
        .NUM_ITEMS (NUM_ITEMS),
        .STOCK_W   (STOCK_W),
        .INIT_STOCK(INIT_STOCK),
        .LOW_THRESH(LOW_THRESH)
    ) u_stock (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_i      (sel_go),
        .dec_item_i (select_item_i),
        .rs_i       (restock_i),
        .rs_item_i  (restock_item_i),
        .rs_qty_i   (restock_qty_i),
        .low_stock_o(low_stock_o),
        .sold_out_o (sold_out)
    );

    assign sold_out_o      = sold_out;
    assign dispense_o      = dispense_q;
    assign dispense_item_o = item_q;
    assign deny_o          = deny_q;
    assign coin_reject_o   = coin_reject_q;
    assign change_valid_o  = change_valid_q;
    assign change_coin_o   = change_coin_q;
    assign balance_o       = bal_q;
    assign busy_o          = state_q != S_IDLE;
endmodule
